// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel synchronizer, debouncer, edge pulses
// and optional auto-repeat. One btn_chan instance per button.

module btn_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE    = RW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} rstate_t;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          deb_q, deb_d;
    logic          lvl_q, press_q, rel_q, rep_q, rep_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rstate_t       state_q, state_d;
    logic          rise, fall;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatch cycles, accept at the last count.
    always_comb begin
        dcnt_d = dcnt_q;
        deb_d  = deb_q;
        if (sync2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DB_LAST) begin
            deb_d  = sync2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Debounce state, registered level output and edge pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_q  <= '0;
            deb_q   <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            deb_q   <= deb_d;
            lvl_q   <= deb_q;
            press_q <= rise;
            rel_q   <= fall;
            rep_q   <= rep_d;
        end
    end

    // Edges of the accepted level, seen one cycle before the output pulses.
    assign rise = deb_q & ~lvl_q;
    assign fall = ~deb_q & lvl_q;

    // Repeat FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Repeat FSM next state; the press cycle counts as 1, release beats repeat.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        if (!REPEAT_EN || fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = WAIT;
                        rcnt_d  = R_ONE;
                    end
                end
                WAIT: begin
                    if (rcnt_q == R_DELAY) begin
                        rep_d   = 1'b1;
                        state_d = REPEAT;
                        rcnt_d  = R_ONE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt_q == R_PERIOD) begin
                        rep_d  = 1'b1;
                        rcnt_d = R_ONE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    assign level_o   = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign repeat_o  = rep_q;
endmodule

module btn_conditioner #(
    parameter int                  NUM_BTNS        = 5,
    parameter int                  DEBOUNCE_CYCLES = 1_000_000,
    parameter int                  REPEAT_DELAY    = 50_000_000,
    parameter int                  REPEAT_PERIOD   = 10_000_000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b01100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat
);
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[g])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (btn_raw[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g]),
            .repeat_o (btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
// Edge e: the raw value set just before it is captured by the first sync flop.

module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
    int checks   = 0;
    int failures = 0;

    btn_conditioner #(
        .NUM_BTNS(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5), .REPEAT_MASK(5'b01100)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw = '0;
        repeat (3) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'h0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
        end
    endtask

    // Channel 0: press at 6, release at 26, never repeats (masked off).
    task automatic test_clean_press();
        for (int e = 0; e < 40; e++) begin
            btn_raw[0] = (e < 20);
            tick();
            checks++;
            if (btn_level[0] !== (e >= 6 && e < 26)) begin
                failures++; $display("FAIL clean_level e=%0d got=%b want=%b", e, btn_level[0], (e >= 6 && e < 26));
            end
            checks++;
            if (btn_press[0] !== (e == 6)) begin
                failures++; $display("FAIL clean_press e=%0d got=%b want=%b", e, btn_press[0], (e == 6));
            end
            checks++;
            if (btn_release[0] !== (e == 26)) begin
                failures++; $display("FAIL clean_release e=%0d got=%b want=%b", e, btn_release[0], (e == 26));
            end
            checks++;
            if (btn_repeat !== 5'b0) begin
                failures++; $display("FAIL clean_repeat e=%0d got=%b want=00000", e, btn_repeat);
            end
        end
    endtask

    // Channel 2 bounces 1,0,1,0 then holds 1 from edge 8; level rises at 14.
    task automatic test_bounce();
        int presses = 0;
        int releases = 0;
        for (int e = 0; e < 44; e++) begin
            btn_raw[2] = (e < 8) ? ((e / 2) % 2 == 0) : (e < 28);
            tick();
            presses  += int'(btn_press[2]);
            releases += int'(btn_release[2]);
            checks++;
            if (btn_level[2] !== (e >= 14 && e < 34)) begin
                failures++; $display("FAIL bounce_level e=%0d got=%b want=%b", e, btn_level[2], (e >= 14 && e < 34));
            end
            checks++;
            if (btn_press[2] !== (e == 14)) begin
                failures++; $display("FAIL bounce_press e=%0d got=%b want=%b", e, btn_press[2], (e == 14));
            end
        end
        checks++;
        if (presses != 1) begin
            failures++; $display("FAIL bounce_press_count got=%0d want=1", presses);
        end
        checks++;
        if (releases != 1) begin
            failures++; $display("FAIL bounce_release_count got=%0d want=1", releases);
        end
    endtask

    // Channel 2 held 40 cycles: press 6, repeats 16,21..41, release 46 wins over 46.
    task automatic test_autorepeat();
        int reps = 0;
        logic rexp;
        for (int e = 0; e < 60; e++) begin
            btn_raw[2] = (e < 40);
            tick();
            rexp = (e >= 16 && e < 46 && (e - 16) % 5 == 0);
            reps += int'(btn_repeat[2]);
            checks++;
            if (btn_repeat[2] !== rexp) begin
                failures++; $display("FAIL repeat_pulse e=%0d got=%b want=%b", e, btn_repeat[2], rexp);
            end
            checks++;
            if (btn_press[2] !== (e == 6)) begin
                failures++; $display("FAIL repeat_press e=%0d got=%b want=%b", e, btn_press[2], (e == 6));
            end
            checks++;
            if (btn_release[2] !== (e == 46)) begin
                failures++; $display("FAIL repeat_release e=%0d got=%b want=%b", e, btn_release[2], (e == 46));
            end
            checks++;
            if (int'(btn_press[2]) + int'(btn_release[2]) + int'(btn_repeat[2]) > 1) begin
                failures++; $display("FAIL pulse_exclusive e=%0d got=%b%b%b want=at most one", e, btn_press[2], btn_release[2], btn_repeat[2]);
            end
        end
        checks++;
        if (reps != 6) begin
            failures++; $display("FAIL repeat_count got=%0d want=6", reps);
        end
    endtask

    // Release sampled at edge 15 lands on edge 21, the second repeat slot.
    task automatic test_collision();
        for (int e = 0; e < 32; e++) begin
            btn_raw[2] = (e < 15);
            tick();
            checks++;
            if (btn_repeat[2] !== (e == 16)) begin
                failures++; $display("FAIL collision_repeat e=%0d got=%b want=%b", e, btn_repeat[2], (e == 16));
            end
            checks++;
            if (btn_release[2] !== (e == 21)) begin
                failures++; $display("FAIL collision_release e=%0d got=%b want=%b", e, btn_release[2], (e == 21));
            end
        end
    endtask

    // Reset while channel 3 is held: outputs clear at once, fresh press at 6 after.
    task automatic test_reset_midhold();
        btn_raw[3] = 1'b1;
        repeat (10) tick();
        checks++;
        if (btn_level[3] !== 1'b1) begin
            failures++; $display("FAIL midhold_level_before got=%b want=1", btn_level[3]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'h0) begin
            failures++; $display("FAIL midhold_async_clear got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'h0) begin
                failures++; $display("FAIL midhold_in_reset c=%0d got=%h want=0", c, {btn_level, btn_press, btn_release, btn_repeat});
            end
        end
        rst = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (btn_press[3] !== (e == 6)) begin
                failures++; $display("FAIL midhold_press e=%0d got=%b want=%b", e, btn_press[3], (e == 6));
            end
            checks++;
            if (btn_release !== 5'b0) begin
                failures++; $display("FAIL midhold_release e=%0d got=%b want=00000", e, btn_release);
            end
        end
        btn_raw[3] = 1'b0;
        repeat (10) tick();
    endtask

    // Channels 0 and 4 together press and release in the same cycle.
    task automatic test_simultaneous();
        logic [4:0] pat;
        pat = 5'b10001;
        btn_raw = pat;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (btn_press !== ((e == 6) ? pat : 5'b0)) begin
                failures++; $display("FAIL simul_press e=%0d got=%b want=%b", e, btn_press, (e == 6) ? pat : 5'b0);
            end
        end
        btn_raw = '0;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (btn_release !== ((e == 6) ? pat : 5'b0)) begin
                failures++; $display("FAIL simul_release e=%0d got=%b want=%b", e, btn_release, (e == 6) ? pat : 5'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        repeat (4) tick();
        test_bounce();
        repeat (4) tick();
        test_autorepeat();
        repeat (4) tick();
        test_collision();
        repeat (4) tick();
        test_reset_midhold();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
